adda_resamp_core: RTL and testbench

Single-clock, multi-channel resampling datapath that replaces the discrete downsample, FIFO, attenuate, FIFO and interpolate stages between the ADC and DAC drivers. It sits after the ADC driver (samples already in the system clock domain) and before the DAC driver. It decimates by 2^RATE_LOG2 using block averaging, applies a programmable attenuation, and buffers the result in an internal FIFO. It then interpolates back up in either hold or linear mode, paced by a DAC tick, and keeps sticky overflow and underrun status.

---
 rtl/adda_resamp_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_adda_resamp_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adda_resamp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adda_resamp_core                                                |
// | Purpose  : block-average decimator, attenuator, FIFO and hold/linear       |
// |            interpolator between the ADC and DAC drivers.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module adda_resamp_core #(
    parameter int DATA_WIDTH = 14,
    parameter int RATE_LOG2  = 2,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic                               in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]     in_data,
    input  logic [1:0]                         gain_shift,
    input  logic                               mode,
    input  logic                               dac_tick,
    input  logic                               clr_status,
    output logic [CHANNELS*DATA_WIDTH-1:0]     out_data,
    output logic                               out_valid,
    output logic                               overflow,
    output logic                               underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level
);

    localparam int c_w     = CHANNELS * DATA_WIDTH;
    localparam int c_aw    = DATA_WIDTH + RATE_LOG2;
    localparam int c_pw    = DATA_WIDTH + RATE_LOG2 + 2;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_prime = FIFO_DEPTH / 2;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_prime = 3'd1;
    localparam logic [2:0] c_st_pop1  = 3'd2;
    localparam logic [2:0] c_st_pop2  = 3'd3;
    localparam logic [2:0] c_st_run   = 3'd4;

    // ---------------- decimator ----------------
    logic [RATE_LOG2-1:0] r_phase;
    logic                 w_last_phase;
    logic [3:0]           w_shamt;
    logic [c_w-1:0]       w_dec_data;
    logic [c_w-1:0]       r_dec_data;
    logic                 r_dec_valid;

    assign w_last_phase = (r_phase == {RATE_LOG2{1'b1}});
    assign w_shamt      = 4'(RATE_LOG2) + {2'b00, gain_shift};

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_dec
            logic signed [DATA_WIDTH-1:0] w_smp;
            logic signed [c_aw-1:0]       w_sum;
            logic signed [c_aw-1:0]       r_acc;

            assign w_smp = $signed(in_data[g*DATA_WIDTH +: DATA_WIDTH]);
            assign w_sum = r_acc + $signed({{RATE_LOG2{w_smp[DATA_WIDTH-1]}}, w_smp});
            // shift is at least RATE_LOG2, so the average always fits the sample width
            assign w_dec_data[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum >>> w_shamt);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (!ena) begin
                    r_acc <= '0;
                end else if (in_valid) begin
                    r_acc <= w_last_phase ? '0 : w_sum;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= '0;
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
        end else if (!ena) begin
            r_phase     <= '0;
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= in_valid && w_last_phase;
            if (in_valid) begin
                r_phase <= r_phase + 1'b1;
                if (w_last_phase) begin
                    r_dec_data <= w_dec_data;
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [c_w-1:0]     r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_w-1:0]     w_head;
    logic               w_pop_req;
    logic               w_empty;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_ovf_evt;
    logic               w_unf_evt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = w_pop_req && !w_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_do_push = ena && r_dec_valid && (!w_full || w_do_pop);
    assign w_ovf_evt = ena && r_dec_valid && w_full && !w_do_pop;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= r_dec_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!ena) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign fill_level = r_count;

    // ---------------- interpolator ----------------
    logic [2:0]           r_state;
    logic [c_w-1:0]       r_prev;
    logic [c_w-1:0]       r_cur;
    logic [RATE_LOG2-1:0] r_k;
    logic                 w_k_last;
    logic [c_w-1:0]       w_out;

    assign w_k_last  = (r_k == {RATE_LOG2{1'b1}});
    assign w_pop_req = ena && ((r_state == c_st_pop1) || (r_state == c_st_pop2) ||
                               ((r_state == c_st_run) && dac_tick && w_k_last));
    assign w_unf_evt = ena && (r_state == c_st_run) && dac_tick && w_k_last && w_empty;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_interp
            logic signed [DATA_WIDTH-1:0] w_p;
            logic signed [DATA_WIDTH-1:0] w_c;
            logic signed [DATA_WIDTH:0]   w_diff;
            logic signed [c_pw-1:0]       w_prod;
            logic signed [c_pw-1:0]       w_step;
            logic signed [c_pw-1:0]       w_pext;

            assign w_p    = $signed(r_prev[g*DATA_WIDTH +: DATA_WIDTH]);
            assign w_c    = $signed(r_cur[g*DATA_WIDTH +: DATA_WIDTH]);
            assign w_diff = {w_c[DATA_WIDTH-1], w_c} - {w_p[DATA_WIDTH-1], w_p};
            assign w_prod = $signed({{(c_pw-DATA_WIDTH-1){w_diff[DATA_WIDTH]}}, w_diff}) *
                            $signed({{(c_pw-RATE_LOG2){1'b0}}, r_k});
            assign w_step = w_prod >>> RATE_LOG2;
            assign w_pext = $signed({{(c_pw-DATA_WIDTH){w_p[DATA_WIDTH-1]}}, w_p});
            assign w_out[g*DATA_WIDTH +: DATA_WIDTH] =
                mode ? DATA_WIDTH'(w_pext + w_step) : r_prev[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_prev    <= '0;
            r_cur     <= '0;
            r_k       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!ena) begin
                r_state  <= c_st_idle;
                r_prev   <= '0;
                r_cur    <= '0;
                r_k      <= '0;
                out_data <= '0;
            end else begin
                case (r_state)
                    c_st_idle: r_state <= c_st_prime;
                    c_st_prime: begin
                        if (r_count >= c_cnt_w'(c_prime)) r_state <= c_st_pop1;
                    end
                    c_st_pop1: begin
                        r_prev  <= w_head;
                        r_state <= c_st_pop2;
                    end
                    c_st_pop2: begin
                        r_cur   <= w_head;
                        r_k     <= '0;
                        r_state <= c_st_run;
                    end
                    c_st_run: begin
                        if (dac_tick) begin
                            out_valid <= 1'b1;
                            out_data  <= w_out;
                            r_k       <= r_k + 1'b1;
                            if (w_k_last) begin
                                r_prev <= r_cur;
                                // on underrun cur is kept so the output flattens
                                if (!w_empty) r_cur <= w_head;
                            end
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    // ---------------- sticky status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (w_ovf_evt)       overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;
            if (w_unf_evt)       underrun <= 1'b1;
            else if (clr_status) underrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adda_resamp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_adda_resamp_core                                             |
// | Purpose  : self-checking bench: vector table, corner sequences, random run |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_adda_resamp_core;

    localparam int DW    = 14;
    localparam int CH    = 2;
    localparam int RL    = 2;
    localparam int R     = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             in_valid;
    logic [CH*DW-1:0] in_data;
    logic [1:0]       gain_shift;
    logic             mode;
    logic             dac_tick;
    logic             clr_status;
    logic [CH*DW-1:0] out_data;
    logic             out_valid;
    logic             overflow;
    logic             underrun;
    logic [4:0]       fill_level;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int s0[4];
        int s1[4];
        int g;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    adda_resamp_core #(
        .DATA_WIDTH(DW),
        .RATE_LOG2 (RL),
        .CHANNELS  (CH),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .gain_shift(gain_shift),
        .mode      (mode),
        .dac_tick  (dac_tick),
        .clr_status(clr_status),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overflow  (overflow),
        .underrun  (underrun),
        .fill_level(fill_level)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ch_out(input int c);
        logic signed [DW-1:0] v;
        v = out_data[c*DW +: DW];
        return int'(v);
    endfunction

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data = '0; gain_shift = 2'd0;
        mode = 1'b0; dac_tick = 1'b0; clr_status = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic push_sample(input int v0, input int v1, input int g);
        in_valid   = 1'b1;
        in_data    = {DW'(v1), DW'(v0)};
        gain_shift = 2'(g);
        cyc(1);
        in_valid   = 1'b0;
    endtask

    task automatic push_const(input int v0, input int v1);
        repeat (R) push_sample(v0, v1, 0);
    endtask

    task automatic tick_check(input string name, input int m, input int e0, input int e1,
                              input int gap);
        mode     = m[0];
        dac_tick = 1'b1;
        cyc(1);
        dac_tick = 1'b0;
        check({name, " valid"}, int'(out_valid), 1);
        check({name, " ch0"}, ch_out(0), e0);
        check({name, " ch1"}, ch_out(1), e1);
        cyc(gap - 1);
    endtask

    task automatic set_vec(input int i, input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input int g, input int e0, input int e1);
        tbl[i].s0[0] = a0; tbl[i].s0[1] = a1; tbl[i].s0[2] = a2; tbl[i].s0[3] = a3;
        tbl[i].s1[0] = b0; tbl[i].s1[1] = b1; tbl[i].s1[2] = b2; tbl[i].s1[3] = b3;
        tbl[i].g = g; tbl[i].e0 = e0; tbl[i].e1 = e1;
    endtask

    task automatic run_interp(input int m);
        int e0;
        do_reset();
        ena = 1'b1;
        push_const(0, 0);
        repeat (7) push_const(40, -40);
        cyc(8);
        for (int t = 0; t < 8; t++) begin
            if (m == 1) e0 = (t < 4) ? 10 * t : 40;
            else        e0 = (t < 4) ? 0 : 40;
            tick_check($sformatf("interp m%0d t%0d", m, t), m, e0, -e0, 4);
        end
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int e0, e1, m;
        int ent0[$];
        int ent1[$];

        // expected entries computed by hand: floor(sum / 2^(2+g))
        set_vec(0, 4, 8, 12, 16,  -3, -3, -3, -4,  0, 10, -4);
        set_vec(1, 4, 8, 12, 16,  -3, -3, -3, -4,  1, 5, -2);
        set_vec(2, 4, 8, 12, 16,  -3, -3, -3, -4,  3, 1, -1);
        set_vec(3, 8191, 8191, 8191, 8191,  -8192, -8192, -8192, -8192,  0, 8191, -8192);
        set_vec(4, 1, 2, 3, 4,  -1, 0, 0, 0,  0, 2, -1);
        set_vec(5, 100, -100, 50, -50,  7, 7, 7, 7,  2, 0, 1);
        set_vec(6, -8192, -8192, -8192, -8192,  8191, 8191, 8191, 8191,  1, -4096, 4095);
        set_vec(7, 1000, 1000, 1000, 1000,  -1000, -1000, -1000, -1000,  0, 1000, -1000);
        set_vec(8, 0, 0, 0, 1,  0, 0, 0, -1,  0, 0, -1);
        set_vec(9, 5, 6, 7, 8,  -5, -6, -7, -8,  1, 3, -4);

        // reset values while rst is held
        rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data = '0; gain_shift = 2'd0;
        mode = 1'b0; dac_tick = 1'b0; clr_status = 1'b0;
        cyc(2);
        check("reset out_data", int'(out_data), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset underrun", int'(underrun), 0);
        check("reset fill", int'(fill_level), 0);
        rst = 1'b0;
        cyc(1);

        // ticks in IDLE and PRIME produce nothing
        dac_tick = 1'b1; cyc(1); dac_tick = 1'b0;
        check("idle tick valid", int'(out_valid), 0);
        ena = 1'b1; cyc(3);
        dac_tick = 1'b1; cyc(1); dac_tick = 1'b0;
        check("prime tick valid", int'(out_valid), 0);

        // decimation table, observed through hold-mode output
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 10; i++)
            for (int s = 0; s < 4; s++)
                push_sample(tbl[i].s0[s], tbl[i].s1[s], tbl[i].g);
        cyc(8);
        check("table fill", int'(fill_level), 8);
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < 4; k++)
                tick_check($sformatf("vec%0d k%0d", i, k), 0,
                           tbl[(i < 10) ? i : 9].e0, tbl[(i < 10) ? i : 9].e1, 3);
            if (i == 7) check("table underrun early", int'(underrun), 0);
            if (i == 8) check("table underrun", int'(underrun), 1);
        end
        check("table overflow", int'(overflow), 0);

        // linear and hold interpolation
        run_interp(1);
        run_interp(0);

        // overflow: 19 results, 2 taken by priming, 16 stored, last dropped
        do_reset();
        ena = 1'b1;
        for (int j = 0; j < 19; j++) push_const(10 * j, -10 * j);
        cyc(6);
        check("ovf fill", int'(fill_level), 16);
        check("ovf flag", int'(overflow), 1);
        check("ovf underrun", int'(underrun), 0);
        clr_status = 1'b1; cyc(1); clr_status = 1'b0;
        check("ovf cleared", int'(overflow), 0);
        for (int j = 0; j < 19; j++) begin
            e0 = (j < 18) ? 10 * j : 170;
            for (int k = 0; k < 4; k++)
                tick_check($sformatf("drain%0d k%0d", j, k), 0, e0, -e0, 2);
        end
        check("drain underrun", int'(underrun), 1);
        check("drain out flat", ch_out(0), 170);

        // ena drop: flush, zero output, flags kept, then re-prime
        repeat (8) push_const(3, -3);
        cyc(3);
        check("pre-drop fill", int'(fill_level), 8);
        ena = 1'b0;
        cyc(1);
        check("drop fill", int'(fill_level), 0);
        check("drop out_data", int'(out_data), 0);
        check("drop underrun kept", int'(underrun), 1);
        check("drop overflow kept", int'(overflow), 0);
        ena = 1'b1;
        repeat (8) push_const(7, -7);
        cyc(8);
        check("reprime out_data", int'(out_data), 0);
        check("reprime fill", int'(fill_level), 6);
        for (int k = 0; k < 4; k++)
            tick_check($sformatf("reprime k%0d", k), 0, 7, -7, 3);

        // asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check("arst out_data", int'(out_data), 0);
        check("arst fill", int'(fill_level), 0);
        check("arst underrun", int'(underrun), 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // randomized rounds against a reference model
        for (int r = 0; r < 3; r++) begin
            ent0.delete();
            ent1.delete();
            do_reset();
            ena = 1'b1;
            for (int b = 0; b < 12; b++) begin
                int g, sum0, sum1, v0, v1;
                g = int'($urandom_range(0, 3));
                sum0 = 0; sum1 = 0;
                for (int s = 0; s < 4; s++) begin
                    v0 = int'($urandom_range(0, 16383)) - 8192;
                    v1 = int'($urandom_range(0, 16383)) - 8192;
                    sum0 += v0; sum1 += v1;
                    if ($urandom_range(0, 1) == 1) begin
                        in_valid = 1'b0; cyc(1);
                    end
                    push_sample(v0, v1, g);
                end
                ent0.push_back(fdiv(sum0, 1 << (RL + g)));
                ent1.push_back(fdiv(sum1, 1 << (RL + g)));
            end
            cyc(8);
            for (int i = 0; i < 11; i++) begin
                for (int k = 0; k < 4; k++) begin
                    m = int'($urandom_range(0, 1));
                    if (m == 1) begin
                        e0 = ent0[i] + fdiv((ent0[i+1] - ent0[i]) * k, R);
                        e1 = ent1[i] + fdiv((ent1[i+1] - ent1[i]) * k, R);
                    end else begin
                        e0 = ent0[i];
                        e1 = ent1[i];
                    end
                    tick_check($sformatf("rnd%0d g%0d k%0d", r, i, k), m, e0, e1,
                               int'($urandom_range(2, 5)));
                end
                if (i == 9)  check($sformatf("rnd%0d no underrun", r), int'(underrun), 0);
                if (i == 10) check($sformatf("rnd%0d underrun", r), int'(underrun), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
